// File: rtl/sip_shift_accum_pkg.sv
// Shared widths and FSM encoding for the SIP shift-accumulate stage.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Optional feature macro used by the design files: SIP_SHIFT_ACCUM_SAT_EN.
package sip_shift_accum_pkg;

  // Width of the signed partial sum produced by the SIP dot adder.
  localparam int BITS_SIP_DOT_ADDER = 12;
  localparam int SIP_BITS_SHIFT     = 4;
  localparam int SIP_BITS_ACC       = 24;
  localparam int SIP_BITS_BEAT      = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/sip_shift_term.sv
// Sign-extends one partial sum and shifts it left by its bit significance.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: i_psum (signed partial sum), i_shift (left-shift amount),
//        o_term (BITS_ACC-bit term), o_ovf (significant bits lost above BITS_ACC).
// Macro SIP_SHIFT_ACCUM_SAT_EN: when defined, o_term clamps by the sign of i_psum
// on overflow; otherwise o_term is the two's-complement wrapped value.
module sip_shift_term
  import sip_shift_accum_pkg::*;
#(
  parameter int BITS_IN    = BITS_SIP_DOT_ADDER,
  parameter int BITS_SHIFT = SIP_BITS_SHIFT,
  parameter int BITS_ACC   = SIP_BITS_ACC
) (
  input  logic [BITS_IN-1:0]    i_psum,
  input  logic [BITS_SHIFT-1:0] i_shift,
  output logic [BITS_ACC-1:0]   o_term,
  output logic                  o_ovf
);

  // Wide enough to hold any shifted value exactly, so overflow is a simple
  // "upper bits are not a pure sign extension" test.
  localparam int W = BITS_ACC + (2 ** BITS_SHIFT);

  logic [W-1:0] ext;
  logic [W-1:0] shifted;
  logic [W-BITS_ACC:0] top;

  always_comb begin
    ext     = {{(W-BITS_IN){i_psum[BITS_IN-1]}}, i_psum};
    shifted = ext << i_shift;
    // Bits from the accumulator sign bit upward must all agree.
    top     = shifted[W-1:BITS_ACC-1];
    o_ovf   = !((&top) || !(|top));
`ifdef SIP_SHIFT_ACCUM_SAT_EN
    if (o_ovf) begin
      o_term = i_psum[BITS_IN-1] ? {1'b1, {(BITS_ACC-1){1'b0}}}
                                 : {1'b0, {(BITS_ACC-1){1'b1}}};
    end else begin
      o_term = shifted[BITS_ACC-1:0];
    end
`else
    o_term = shifted[BITS_ACC-1:0];
`endif
  end

endmodule

// File: rtl/sip_shift_accum.sv
// Shift-accumulates signed SIP partial dot-sums into one signed dot product per group.
// Latency: result valid one cycle after the accepted last beat.
// Backpressure: o_ready = !o_valid || i_ready; a held result blocks new beats, no bubbles on drain.
// Ports: i_clk/i_rst_n (sync active-low reset); beat in: i_valid/o_ready, i_psum,
//        i_shift, i_first, i_last; result out: o_valid/i_ready, o_acc, o_beats, o_ovf.
// Macro SIP_SHIFT_ACCUM_SAT_EN: defined -> accumulation saturates to signed
// BITS_ACC limits; undefined -> two's-complement wrap. o_ovf reports either way.
module sip_shift_accum
  import sip_shift_accum_pkg::*;
#(
  parameter int BITS_IN    = BITS_SIP_DOT_ADDER,
  parameter int BITS_SHIFT = SIP_BITS_SHIFT,
  parameter int BITS_ACC   = SIP_BITS_ACC,
  parameter int BITS_BEAT  = SIP_BITS_BEAT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [BITS_IN-1:0]    i_psum,
  input  logic [BITS_SHIFT-1:0] i_shift,
  input  logic                  i_first,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BITS_ACC-1:0]   o_acc,
  output logic [BITS_BEAT-1:0]  o_beats,
  output logic                  o_ovf
);

  state_e                 state_q, state_d;
  logic [BITS_ACC-1:0]    acc_q, acc_d;
  logic [BITS_BEAT-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic [BITS_ACC-1:0]    res_acc_q, res_acc_d;
  logic [BITS_BEAT-1:0]   res_beats_q, res_beats_d;
  logic                   res_ovf_q, res_ovf_d;

  logic [BITS_ACC-1:0]    term;
  logic                   term_ovf;
  logic [BITS_ACC:0]      sum;
  logic                   add_ovf;
  logic                   beat_acc;
  logic                   start;
  logic [BITS_ACC-1:0]    acc_nx;
  logic [BITS_BEAT-1:0]   cnt_nx;
  logic                   ovf_nx;

  sip_shift_term #(
    .BITS_IN   (BITS_IN),
    .BITS_SHIFT(BITS_SHIFT),
    .BITS_ACC  (BITS_ACC)
  ) u_term (
    .i_psum (i_psum),
    .i_shift(i_shift),
    .o_term (term),
    .o_ovf  (term_ovf)
  );

  assign o_ready = !valid_q || i_ready;

  always_comb begin
    // One extra bit exposes signed overflow of the add.
    sum      = {acc_q[BITS_ACC-1], acc_q} + {term[BITS_ACC-1], term};
    add_ovf  = sum[BITS_ACC] ^ sum[BITS_ACC-1];
    beat_acc = i_valid && o_ready;
    // A beat in IDLE starts a group even without i_first; i_first mid-group
    // drops the open group.
    start    = (state_q == IDLE) || i_first;

    if (start) begin
      acc_nx = term;
      cnt_nx = BITS_BEAT'(1);
      ovf_nx = term_ovf;
    end else begin
`ifdef SIP_SHIFT_ACCUM_SAT_EN
      if (add_ovf) begin
        acc_nx = sum[BITS_ACC] ? {1'b1, {(BITS_ACC-1){1'b0}}}
                               : {1'b0, {(BITS_ACC-1){1'b1}}};
      end else begin
        acc_nx = sum[BITS_ACC-1:0];
      end
`else
      acc_nx = sum[BITS_ACC-1:0];
`endif
      // Beat counter sticks at all-ones; the extra beat is flagged.
      cnt_nx = (&cnt_q) ? cnt_q : cnt_q + BITS_BEAT'(1);
      ovf_nx = ovf_q | term_ovf | add_ovf | (&cnt_q);
    end

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    valid_d     = valid_q;
    res_acc_d   = res_acc_q;
    res_beats_d = res_beats_q;
    res_ovf_d   = res_ovf_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (beat_acc) begin
      if (i_last) begin
        res_acc_d   = acc_nx;
        res_beats_d = cnt_nx;
        res_ovf_d   = ovf_nx;
        valid_d     = 1'b1;
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_nx;
        cnt_d   = cnt_nx;
        ovf_d   = ovf_nx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      res_acc_q   <= '0;
      res_beats_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      res_acc_q   <= res_acc_d;
      res_beats_q <= res_beats_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_acc   = res_acc_q;
  assign o_beats = res_beats_q;
  assign o_ovf   = res_ovf_q;

endmodule

// File: tb/tb_sip_shift_accum.sv
// Bench for sip_shift_accum: table of single-beat groups, hand-written
// multi-cycle sequences, and random traffic against an arithmetic model.
module tb_sip_shift_accum;
  import sip_shift_accum_pkg::*;

  localparam int BI = BITS_SIP_DOT_ADDER;
  localparam int BS = SIP_BITS_SHIFT;
  localparam int BA = SIP_BITS_ACC;
  localparam int BB = SIP_BITS_BEAT;
  localparam longint MAXV = (longint'(1) <<< (BA - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (BA - 1));
  localparam int CNT_MAX = (1 << BB) - 1;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [BI-1:0]        i_psum;
  logic [BS-1:0]        i_shift;
  logic                 i_first;
  logic                 i_last;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [BA-1:0] o_acc;
  logic [BB-1:0]        o_beats;
  logic                 o_ovf;

  sip_shift_accum dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_psum (i_psum),
    .i_shift(i_shift),
    .i_first(i_first),
    .i_last (i_last),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_acc  (o_acc),
    .o_beats(o_beats),
    .o_ovf  (o_ovf)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input longint p, input int s, input bit f, input bit l);
    i_valid = 1'b1;
    i_psum  = BI'(p);
    i_shift = BS'(s);
    i_first = f;
    i_last  = l;
    tick();
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic check_res(input string name, input longint a, input longint b, input bit ov);
    check({name, "_valid"}, o_valid, 1);
    check({name, "_acc"}, o_acc, a);
    check({name, "_beats"}, o_beats, b);
    check({name, "_ovf"}, o_ovf, ov);
  endtask

  // ---------------- reference model (exact integer arithmetic) ----------------
  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & ((longint'(1) <<< BA) - 1);
    if (m > MAXV) m = m - (longint'(1) <<< BA);
    return m;
  endfunction

  function automatic longint clamp_acc(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint fit(input longint v);
`ifdef SIP_SHIFT_ACCUM_SAT_EN
    return clamp_acc(v);
`else
    return wrap_acc(v);
`endif
  endfunction

  bit     g_open;
  longint g_acc;
  int     g_cnt;
  bit     g_ovf;

  task automatic model_beat(input longint p, input int s, input bit f, input bit l,
                            output bit done, output longint ra, output int rb, output bit ro);
    longint exact;
    longint t;
    longint total;
    bit     tov;
    exact = p * (longint'(1) <<< s);
    tov   = (exact > MAXV) || (exact < MINV);
    t     = fit(exact);
    if (!g_open || f) begin
      g_acc = t;
      g_cnt = 1;
      g_ovf = tov;
    end else begin
      total = g_acc + t;
      g_ovf = g_ovf | tov | (total > MAXV) | (total < MINV);
      g_acc = fit(total);
      if (g_cnt == CNT_MAX) g_ovf = 1'b1;
      else g_cnt = g_cnt + 1;
    end
    done = l;
    ra = g_acc;
    rb = g_cnt;
    ro = g_ovf;
    g_open = !l;
  endtask

  typedef struct {
    longint psum;
    int     shift;
    longint exp_acc;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs[8];

  bit     m_valid;
  longint m_acc;
  int     m_beats;
  bit     m_ovf;
  bit     acc_ok;
  bit     done;
  longint ra;
  int     rb;
  bit     ro;

  initial begin
    vecs[0] = '{3, 0, 3, 0};
    vecs[1] = '{-1, 15, -32768, 0};
    vecs[3] = '{-2048, 12, -8388608, 0};
    vecs[6] = '{0, 15, 0, 0};
    vecs[7] = '{-5, 3, -40, 0};
`ifdef SIP_SHIFT_ACCUM_SAT_EN
    vecs[2] = '{2047, 13, 8388607, 1};
    vecs[4] = '{-2048, 13, -8388608, 1};
    vecs[5] = '{1024, 13, 8388607, 1};
`else
    vecs[2] = '{2047, 13, -8192, 1};
    vecs[4] = '{-2048, 13, 0, 1};
    vecs[5] = '{1024, 13, -8388608, 1};
`endif

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_psum  = '0;
    i_shift = '0;
    i_first = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_acc", o_acc, 0);
    check("rst_beats", o_beats, 0);
    check("rst_ovf", o_ovf, 0);
    i_rst_n = 1'b1;

    // Table of one-beat groups (first && last).
    for (int i = 0; i < 8; i++) begin
      beat(vecs[i].psum, vecs[i].shift, 1'b1, 1'b1);
      check_res($sformatf("vec%0d", i), vecs[i].exp_acc, 1, vecs[i].exp_ovf);
    end
    tick();
    check("vec_drain", o_valid, 0);

    // Basic group: 3 - 4 + 8 = 7, valid exactly one cycle after the last beat.
    beat(3, 0, 1'b1, 1'b0);
    beat(-2, 1, 1'b0, 1'b0);
    check("basic_not_yet", o_valid, 0);
    beat(1, 3, 1'b0, 1'b1);
    check_res("basic", 7, 3, 0);
    tick();
    check("basic_drained", o_valid, 0);

    // Reset mid-group, with a last beat offered during reset; reset wins.
    beat(5, 0, 1'b1, 1'b0);
    beat(3, 1, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    i_valid = 1'b1; i_psum = BI'(9); i_shift = '0; i_last = 1'b1;
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    i_rst_n = 1'b1;
    check("midrst_valid", o_valid, 0);
    check("midrst_acc", o_acc, 0);
    // Beat without i_first in IDLE starts a group implicitly.
    beat(7, 0, 1'b0, 1'b1);
    check_res("after_rst", 7, 1, 0);
    tick();

    // Backpressure: A held, B waits, drains and loads in the same cycle.
    i_ready = 1'b0;
    beat(10, 0, 1'b1, 1'b1);
    check_res("bp_a", 10, 1, 0);
    i_valid = 1'b1; i_psum = BI'(-6); i_shift = '0; i_first = 1'b1; i_last = 1'b1;
    #1;
    check("bp_ready_low", o_ready, 0);
    tick();
    check("bp_hold_acc", o_acc, 10);
    check("bp_hold_valid", o_valid, 1);
    i_ready = 1'b1;
    #1;
    check("bp_ready_high", o_ready, 1);
    tick();
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    check_res("bp_b", -6, 1, 0);
    tick();
    check("bp_drained", o_valid, 0);

    // Restart: i_first mid-group drops 100 + 50.
    beat(100, 0, 1'b1, 1'b0);
    beat(50, 0, 1'b0, 1'b0);
    beat(9, 0, 1'b1, 1'b0);
    beat(1, 1, 1'b0, 1'b1);
    check_res("restart", 11, 2, 0);
    tick();

    // Idle gaps between beats change nothing.
    for (int i = 0; i < 4; i++) begin
      beat(1, 0, i == 0, i == 3);
      if (i != 3) begin
        tick();
      end
    end
    check_res("gaps", 4, 4, 0);
    tick();

    // Accumulator overflow: 2 * (2047 << 12) exceeds the signed range.
    beat(2047, 12, 1'b1, 1'b0);
    beat(2047, 12, 1'b0, 1'b1);
`ifdef SIP_SHIFT_ACCUM_SAT_EN
    check_res("add_ovf", 8388607, 2, 1);
`else
    check_res("add_ovf", -8192, 2, 1);
`endif
    tick();

    // Beat count saturation: 32 beats of 1.
    for (int i = 0; i < 32; i++) begin
      beat(1, 0, i == 0, i == 31);
    end
    check_res("cnt_sat", 32, CNT_MAX, 1);
    tick();

    // Random traffic vs model.
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    g_open  = 1'b0;
    m_valid = 1'b0;
    m_acc   = 0;
    m_beats = 0;
    m_ovf   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_psum  = BI'($urandom);
      i_shift = BS'($urandom_range(0, 15));
      i_first = ($urandom_range(0, 7) == 0);
      i_last  = ($urandom_range(0, 4) == 0);
      i_ready = ($urandom_range(0, 9) < 7);
      #1;
      check("rnd_ready", o_ready, longint'(!m_valid || i_ready));
      acc_ok = i_valid && (!m_valid || i_ready);
      if (m_valid && i_ready) m_valid = 1'b0;
      if (acc_ok) begin
        model_beat(longint'($signed(i_psum)), int'(i_shift), i_first, i_last, done, ra, rb, ro);
        if (done) begin
          m_valid = 1'b1;
          m_acc   = ra;
          m_beats = rb;
          m_ovf   = ro;
        end
      end
      tick();
      check("rnd_valid", o_valid, m_valid);
      if (m_valid) begin
        check("rnd_acc", o_acc, m_acc);
        check("rnd_beats", o_beats, m_beats);
        check("rnd_ovf", o_ovf, m_ovf);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
